// File: rtl/switch_select_decoder_if.sv
// Switch/selection bundle between the raw board switches and the LED demux.
// Strobe semantics: o_Select_Valid is a one-cycle, registered pulse issued on
// the same edge that o_Select takes a new value. There is no ready; the
// consumer must sample o_Select on the cycle the pulse is high. o_Press_n and
// o_Release_n are one-cycle pulses coincident with the matching Stable edge.
interface switch_select_decoder_if;
  logic       i_Switch_1;
  logic       i_Switch_2;
  logic       o_Switch_1_Stable;
  logic       o_Switch_2_Stable;
  logic       o_Press_1;
  logic       o_Press_2;
  logic       o_Release_1;
  logic       o_Release_2;
  logic [1:0] o_Select;
  logic       o_Select_Valid;
  // Debounce FSM state per switch, for observation only.
  logic [1:0] o_Dbg_State_1;
  logic [1:0] o_Dbg_State_2;

  modport slave (
    input  i_Switch_1, i_Switch_2,
    output o_Switch_1_Stable, o_Switch_2_Stable,
    output o_Press_1, o_Press_2, o_Release_1, o_Release_2,
    output o_Select, o_Select_Valid,
    output o_Dbg_State_1, o_Dbg_State_2
  );

  modport master (
    output i_Switch_1, i_Switch_2,
    input  o_Switch_1_Stable, o_Switch_2_Stable,
    input  o_Press_1, o_Press_2, o_Release_1, o_Release_2,
    input  o_Select, o_Select_Valid,
    input  o_Dbg_State_1, o_Dbg_State_2
  );
endinterface

// File: rtl/switch_select_decoder.sv
// Two-switch front end: synchronise, debounce, emit stable levels, press and
// release pulses, and a registered 2-bit select code with a change strobe.
module switch_select_decoder #(
  parameter int DEBOUNCE_LIMIT = 250000,
  parameter int CNT_WIDTH      = 24
) (
  input logic                    i_Clk,
  input logic                    i_Rst_L,
  switch_select_decoder_if.slave io_Sw
);

  typedef enum logic [1:0] {
    RELEASED        = 2'd0,
    CONFIRM_PRESS   = 2'd1,
    PRESSED         = 2'd2,
    CONFIRM_RELEASE = 2'd3
  } state_t;

  // Last count value before a confirmation completes; counter never passes it.
  localparam logic [CNT_WIDTH-1:0] LP_LAST = CNT_WIDTH'(DEBOUNCE_LIMIT - 1);
  localparam logic [CNT_WIDTH-1:0] LP_ONE  = CNT_WIDTH'(1);

  logic [1:0] w_Raw;
  logic [1:0] w_Stable;
  logic [1:0] w_Press;
  logic [1:0] w_Release;
  logic [1:0] w_Done;
  logic [3:0] w_State_Dbg;
  logic [1:0] r_Select;
  logic       r_Select_Valid;

  assign w_Raw = {io_Sw.i_Switch_2, io_Sw.i_Switch_1};

  for (genvar g = 0; g < 2; g++) begin : g_sw
    logic                 r_Sync_1;
    logic                 r_Sync_2;
    state_t               r_State;
    logic [CNT_WIDTH-1:0] r_Cnt;
    logic                 r_Stable;
    logic                 r_Press;
    logic                 r_Release;
    logic                 w_Done_Local;

    // Two-flop synchroniser for the asynchronous switch pin.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
        r_Sync_1 <= 1'b0;
        r_Sync_2 <= 1'b0;
      end else begin
        r_Sync_1 <= w_Raw[g];
        r_Sync_2 <= r_Sync_1;
      end
    end

    // High on the cycle whose edge completes a confirmation (Stable flips).
    assign w_Done_Local = (r_Cnt == LP_LAST) &&
                          (((r_State == CONFIRM_PRESS)   &&  r_Sync_2) ||
                           ((r_State == CONFIRM_RELEASE) && !r_Sync_2));

    // Debounce FSM with registered level and pulse outputs.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
        r_State   <= RELEASED;
        r_Cnt     <= '0;
        r_Stable  <= 1'b0;
        r_Press   <= 1'b0;
        r_Release <= 1'b0;
      end else begin
        r_Press   <= 1'b0;
        r_Release <= 1'b0;
        case (r_State)
          RELEASED: begin
            if (r_Sync_2) begin
              r_State <= CONFIRM_PRESS;
              r_Cnt   <= '0;
            end
          end
          CONFIRM_PRESS: begin
            if (!r_Sync_2) begin
              r_State <= RELEASED;
              r_Cnt   <= '0;
            end else if (r_Cnt == LP_LAST) begin
              r_State  <= PRESSED;
              r_Cnt    <= '0;
              r_Stable <= 1'b1;
              r_Press  <= 1'b1;
            end else begin
              r_Cnt <= r_Cnt + LP_ONE;
            end
          end
          PRESSED: begin
            if (!r_Sync_2) begin
              r_State <= CONFIRM_RELEASE;
              r_Cnt   <= '0;
            end
          end
          CONFIRM_RELEASE: begin
            if (r_Sync_2) begin
              r_State <= PRESSED;
              r_Cnt   <= '0;
            end else if (r_Cnt == LP_LAST) begin
              r_State   <= RELEASED;
              r_Cnt     <= '0;
              r_Stable  <= 1'b0;
              r_Release <= 1'b1;
            end else begin
              r_Cnt <= r_Cnt + LP_ONE;
            end
          end
          default: begin
            r_State <= RELEASED;
            r_Cnt   <= '0;
          end
        endcase
      end
    end

    assign w_Done[g]            = w_Done_Local;
    assign w_Stable[g]          = r_Stable;
    assign w_Press[g]           = r_Press;
    assign w_Release[g]         = r_Release;
    assign w_State_Dbg[2*g +: 2] = r_State;
  end

  // Select code follows the stable levels on the same edge; strobe on any flip.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_Select       <= 2'b00;
      r_Select_Valid <= 1'b0;
    end else begin
      r_Select       <= w_Stable ^ w_Done;
      r_Select_Valid <= |w_Done;
    end
  end

  assign io_Sw.o_Switch_1_Stable = w_Stable[0];
  assign io_Sw.o_Switch_2_Stable = w_Stable[1];
  assign io_Sw.o_Press_1         = w_Press[0];
  assign io_Sw.o_Press_2         = w_Press[1];
  assign io_Sw.o_Release_1       = w_Release[0];
  assign io_Sw.o_Release_2       = w_Release[1];
  assign io_Sw.o_Select          = r_Select;
  assign io_Sw.o_Select_Valid    = r_Select_Valid;
  assign io_Sw.o_Dbg_State_1     = w_State_Dbg[1:0];
  assign io_Sw.o_Dbg_State_2     = w_State_Dbg[3:2];

endmodule

// File: doc/switch_select_decoder.md
Name: switch_select_decoder

Overview:
- Input-side counterpart to the LED selection/blink path: reads the two raw board switches and turns them into clean, registered selection state.
- Per switch: synchronises, debounces with a 4-state FSM, and emits stable levels plus one-cycle press/release pulses.
- Packs both stable levels into a 2-bit select code, with a valid strobe on every change. This code drives the LED demux select in place of the raw switch pins.

Parameters:
- DEBOUNCE_LIMIT, 250000, number of consecutive confirming samples beyond the first (10 ms at 25 MHz). Legal range 2 .. 2^24-1.
- CNT_WIDTH, 24, width of each debounce counter. Must satisfy 2^CNT_WIDTH > DEBOUNCE_LIMIT.

Ports:
- i_Clk  in  1  system clock; all state on rising edge.
- i_Rst_L  in  1  reset, asynchronous assert, active-low.
- i_Switch_1  in  1  raw switch 1, asynchronous, bouncy, 1 = pressed.
- i_Switch_2  in  1  raw switch 2, same as switch 1.
- o_Switch_1_Stable  out  1  debounced level of switch 1.
- o_Switch_2_Stable  out  1  debounced level of switch 2.
- o_Press_1  out  1  one-cycle pulse when switch 1 becomes stable-pressed.
- o_Press_2  out  1  one-cycle pulse when switch 2 becomes stable-pressed.
- o_Release_1  out  1  one-cycle pulse when switch 1 becomes stable-released.
- o_Release_2  out  1  one-cycle pulse when switch 2 becomes stable-released.
- o_Select  out  2  {o_Switch_2_Stable, o_Switch_1_Stable}.
- o_Select_Valid  out  1  one-cycle pulse on any change of o_Select.

Behaviour:
- Reset (i_Rst_L=0, asynchronous): all outputs, synchroniser flops, counters and FSM state go to 0 / RELEASED, immediately and without waiting for a clock edge.
- Reset release: registers update from the first rising edge with i_Rst_L=1. Switches held pressed through reset produce a normal debounced press after release.
- Synchroniser: 2 flops per switch. S_n = second flop output.
- Per-switch FSM (identical, independent), states RELEASED, CONFIRM_PRESS, PRESSED, CONFIRM_RELEASE:
  - RELEASED: if S=1, go CONFIRM_PRESS with count=0.
  - CONFIRM_PRESS:
    - S=0: back to RELEASED, count=0, no pulse.
    - S=1 and count==DEBOUNCE_LIMIT-1: go PRESSED, Stable<=1, Press pulse.
    - otherwise: count+1.
  - PRESSED: if S=0, go CONFIRM_RELEASE with count=0.
  - CONFIRM_RELEASE: mirror of CONFIRM_PRESS with S inverted; on completion go RELEASED, Stable<=0, Release pulse.
- Latency: raw input first sampled high at edge E0 and held → Stable rises and Press pulses at edge E0+DEBOUNCE_LIMIT+2. Release is symmetric.
- Glitch rejection: any bounce shorter than DEBOUNCE_LIMIT+1 consecutive S samples produces no output change.
- Counter saturation: the counter never exceeds DEBOUNCE_LIMIT-1 and never wraps. It is cleared on every FSM transition.
- Pulses: Press/Release are high exactly one cycle, registered, coincident with the Stable edge.
- Select: o_Select is a registered copy of the stable levels, updated on the same edge as the Stable outputs.
- Select_Valid: pulses on that same edge if either Stable changes.
  - Both switches changing on the same edge → one Select_Valid pulse.
  - One switch pressing while the other releases → one pulse, new code.
- No combinational path from any input to any output.

Test Plan:
- Reset: assert i_Rst_L=0 mid-simulation, between clock edges → all outputs 0 before the next edge.
- Clean press, DEBOUNCE_LIMIT=4: i_Switch_1 0→1 sampled at E0 → o_Switch_1_Stable=1 and o_Press_1, o_Select_Valid each high one cycle at E6; o_Select=2'b01.
- Bounce rejection, DEBOUNCE_LIMIT=4: i_Switch_2 toggling with 3-cycle high / 2-cycle low for 40 cycles, then held 1 → no output change during bounce; o_Press_2 exactly once, 6 edges after the final rise is sampled; o_Select=2'b10.
- Simultaneous, DEBOUNCE_LIMIT=4: both switches rise at the same edge → both Stable outputs 1 at E6, o_Select=2'b11, o_Press_1 and o_Press_2 both pulse, exactly one o_Select_Valid pulse.
- Release, DEBOUNCE_LIMIT=4: from 2'b11, drop i_Switch_1 → o_Release_1 pulse at E6, o_Select=2'b10, o_Press_* stay 0.
- Reset mid-confirm, DEBOUNCE_LIMIT=4: press, assert reset at count=2, release reset with the switch still held → full DEBOUNCE_LIMIT+2 edges elapse from the first post-reset sample before o_Press_1; no press pulse during reset.
